// File: rtl/nonce_report_queue.sv
// nonce_report_queue: buffers golden nonces from the hashing cores and hands
// them one at a time to serial_transmit. Consecutive duplicates are dropped.
// Pushes that find no free space raise a sticky overflow flag.
module nonce_report_queue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int BUSY_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              golden_valid,
  input  logic [31:0]       golden_nonce,
  input  logic              tx_busy,
  output logic              tx_send,
  output logic [31:0]       tx_word,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam int WAIT_W = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(BUSY_WAIT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [31:0]       last_nonce;
  logic              last_vld;
  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              send_nxt;
  logic              pop;
  logic              cand;
  logic              push;
  logic              drop;
  logic [ADDR_W:0]   count_nxt;

  // Duplicate filter and push acceptance; a pop in the same cycle frees a slot.
  always_comb begin
    cand = golden_valid && !(last_vld && (golden_nonce == last_nonce));
    push = cand && ((count != DEPTH_C) || pop);
    drop = cand && !push;
  end

  // Send FSM next state: pop and strobe from IDLE, then wait out one busy period.
  always_comb begin
    state_nxt = state;
    send_nxt  = 1'b0;
    wait_nxt  = wait_cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !tx_busy) begin
          pop       = 1'b1;
          send_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        wait_nxt  = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else begin
          // Give up waiting for busy if the transmitter never responds.
          wait_nxt = wait_cnt + WAIT_W'(1);
          if ((wait_cnt + WAIT_W'(1)) == WAIT_LIM) state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy next value; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (ADDR_W + 1)'(1);
      2'b01:   count_nxt = count - (ADDR_W + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Control state: FSM, pointers, occupancy, flags and the outgoing word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_send  <= 1'b0;
      tx_word  <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      tx_send  <= send_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_C);
      if (drop) overflow <= 1'b1;
      if (cand) last_vld <= 1'b1;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_word <= mem[rd_ptr];
      end
    end
  end

  // Data storage: FIFO array and the last-seen nonce carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= golden_nonce;
    if (cand) last_nonce  <= golden_nonce;
  end

endmodule

// File: doc/nonce_report_queue.md
# nonce_report_queue

- Buffers golden nonces from the hashing cores and issues them one at a time to `serial_transmit` as 32-bit words.
- Sits between the core result outputs and `serial_transmit` (`word`/`send`/`busy`).
- Absorbs bursts of results that arrive while the UART is still shifting out an earlier word.
- Drops consecutive duplicate nonces and flags overflow.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of 2, minimum 2.
- `ADDR_W`, default 3: log2(`DEPTH`).
- `BUSY_WAIT`, default 4: cycles to wait for `tx_busy` to rise after a send before giving up.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `golden_valid` in 1: one-cycle strobe; `golden_nonce` is valid.
- `golden_nonce` in 32: nonce to report.
- `tx_busy` in 1: `busy` from `serial_transmit`.
- `tx_send` out 1: one-cycle send strobe to `serial_transmit`; registered.
- `tx_word` out 32: word to `serial_transmit`; registered, held between sends.
- `count` out ADDR_W+1: current FIFO occupancy, range 0..`DEPTH`.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky flag; cleared only by `rst`.

## Operation
- Reset values: `tx_send`=0, `tx_word`=0, `count`=0, `full`=0, `overflow`=0; read/write pointers 0; FSM in IDLE; `last_nonce` valid flag cleared.
- Push is a candidate when `golden_valid`=1.
  - If `last_nonce` is valid and `golden_nonce == last_nonce`, the push is discarded silently. No count change, no overflow.
  - Otherwise `last_nonce` <= `golden_nonce` and its valid flag is set, even if the push is then dropped for lack of space.
- Push acceptance: accepted when `count < DEPTH`, or when a pop happens in the same cycle.
  - Otherwise the nonce is dropped and `overflow` <= 1.
- Pointers are ADDR_W bits and wrap modulo `DEPTH`.
- `count` update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- FSM states:
  - IDLE: if `count != 0` and `tx_busy`=0, then `tx_word` <= FIFO[rd_ptr], pop (rd_ptr+1), `tx_send` <= 1, go to SEND.
  - SEND: `tx_send` <= 0, clear wait counter, go to WAIT_HI.
  - WAIT_HI: if `tx_busy`=1, go to WAIT_LO. Else increment the wait counter; when it reaches `BUSY_WAIT`, go to WAIT_LO anyway.
  - WAIT_LO: when `tx_busy`=0, go to IDLE.
- Each send produces exactly one `tx_send` pulse. A popped word is never resent, even on busy timeout.
- `tx_word` changes only on a pop, so it is stable for the whole cycle in which `tx_send`=1 and afterwards.
- Reset mid-operation: FIFO contents are abandoned. Any word already handed to `serial_transmit` continues there; this block does not track it.

## Timing
- Push latency: `golden_valid` in cycle N → `count` updated in cycle N+1.
- Send latency: with an empty FIFO, IDLE, and `tx_busy`=0, `golden_valid` in cycle N → `tx_send`=1 in cycle N+2, `tx_word` valid from cycle N+2.
- `serial_transmit` raises `busy` the cycle after `send`, so WAIT_HI normally lasts 1 cycle.
- Minimum spacing between `tx_send` pulses: 4 cycles. In practice spacing is set by the 4-byte UART duration.
- Pop happens in the IDLE→SEND transition cycle, so `count` drops in cycle N+2 of the example above.
- Simultaneous full + push + pop: push accepted, `count` stays `DEPTH`, `overflow` unchanged.
- `full` and `count` are registered; no combinational path from `golden_valid` to any output.

## Test plan
- Single nonce 0xDEADBEEF, `tx_busy` modelled as high 2..40 cycles after send → one `tx_send` pulse, `tx_word`=0xDEADBEEF, `count` returns to 0, FSM back in IDLE.
- Three back-to-back strobes 0x1, 0x2, 0x3 while `tx_busy`=1 → `count`=3; after busy drops, sends occur in order 0x1, 0x2, 0x3, each only after the previous busy period ends.
- With `tx_busy` held high, push 9 distinct nonces 0x10..0x18 → `count`=8, `full`=1, 0x18 dropped, `overflow`=1; release busy → 0x10..0x17 delivered; `overflow` stays 1.
- Push 0xAAAA0000 twice, then 0x5, then 0xAAAA0000 → only 3 entries queued (0xAAAA0000, 0x5, 0xAAAA0000).
- Full FIFO, IDLE, busy falls in the same cycle as a new push → push accepted, `count` stays 8, no overflow.
- Assert `rst` during WAIT_LO with 3 entries queued → all outputs at reset values immediately (asynchronous); no further `tx_send`; next push after reset is sent normally.
- `tx_busy` tied 0 (no response) → after a send, FSM returns to IDLE within `BUSY_WAIT`+2 cycles and the next queued word is sent.
